// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-bit positions and bubble masking.
package pipe_pkg;
    localparam int CTRL_W        = 6;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 0;

    // ANDed onto control when no instruction is valid: kills regwrite/memwrite/memread
    localparam logic [CTRL_W-1:0] BUBBLE_MASK = 6'b101001;

    function automatic logic [CTRL_W-1:0] mask_bubble(input logic vld, input logic [CTRL_W-1:0] c);
        return vld ? c : (c & BUBBLE_MASK);
    endfunction
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute handshake bundle; the stage sits on the slave modport.
interface id_ex_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int FW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3*AW-1:0]   in_addr;
    logic [3*DW-1:0]   in_data;
    logic [FW-1:0]     in_alufn;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [3*AW-1:0]   out_addr;
    logic [3*DW-1:0]   out_data;
    logic [FW-1:0]     out_alufn;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_addr, in_data, in_alufn, in_ctrl, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_alufn, out_ctrl
    );
    modport slave (
        input  in_valid, in_addr, in_data, in_alufn, in_ctrl, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_alufn, out_ctrl
    );
endinterface

// File: rtl/id_ex_pipe_reg_skid_buf.sv
// Generic valid/ready register with one skid entry and synchronous flush.
// Latency 1 cycle; in_rdy depends only on registered state (skid empty).
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] main_dat_q, main_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         acc, xfer;

    assign in_rdy  = !skid_vld_q;
    assign out_vld = main_vld_q;
    assign out_dat = main_dat_q;
    assign acc     = in_vld && in_rdy;
    assign xfer    = main_vld_q && out_rdy;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            // payload is left in place; only the valid flags are dropped
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (xfer) begin
            if (skid_vld_q) begin
                main_dat_d = skid_dat_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                main_dat_d = in_dat;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (acc) begin
            if (!main_vld_q) begin
                main_dat_d = in_dat;
                main_vld_d = 1'b1;
            end else begin
                skid_dat_d = in_dat;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: skid-buffered decode->execute handoff with flush and bubble masking.
// Latency 1 cycle; EX back-pressure absorbed by one skid entry, in_ready is registered-only.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int FW = 3,
    parameter int CW = 16
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          flush,
    id_ex_pipe_reg_if.slave p,
    output logic [CW-1:0] stall_cnt
);
    localparam int PW = 3*AW + 3*DW + FW + CTRL_W;

    logic [PW-1:0] in_pay, out_pay;
    logic          out_vld;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    assign in_pay = {p.in_addr, p.in_data, p.in_alufn, p.in_ctrl};

    skid_buf #(.W(PW)) u_skid (
        .clk     (clk1),
        .rst_n   (rst_n),
        .flush   (flush),
        .in_vld  (p.in_valid),
        .in_rdy  (p.in_ready),
        .in_dat  (in_pay),
        .out_vld (out_vld),
        .out_rdy (p.out_ready),
        .out_dat (out_pay)
    );

    assign p.out_valid = out_vld;
    assign p.out_addr  = out_pay[PW-1 -: 3*AW];
    assign p.out_data  = out_pay[FW+CTRL_W +: 3*DW];
    assign p.out_alufn = out_pay[CTRL_W +: FW];
    assign p.out_ctrl  = mask_bubble(out_vld, out_pay[CTRL_W-1:0]);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_vld && !p.out_ready && !flush && (stall_cnt_q != {CW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (CW=4 so saturation is reachable).
module tb_id_ex_pipe_reg;
    logic       clk1;
    logic       rst_n;
    logic       flush;
    logic [3:0] stall_cnt;
    int         checks = 0;
    int         errors = 0;

    // payload layout {addr[8:0], data[23:0], alufn[2:0], ctrl[5:0]}
    logic [41:0] pay_a = {3'd1, 3'd2, 3'd3, 8'h05, 8'h10, 8'h20, 3'd2, 6'b010010};
    logic [41:0] pay_b = {3'd4, 3'd5, 3'd6, 8'h33, 8'h44, 8'h55, 3'd5, 6'b100111};
    logic [41:0] pay_c = {3'd7, 3'd7, 3'd7, 8'hAA, 8'hBB, 8'hCC, 3'd7, 6'b111111};
    logic [41:0] pay_f = {3'd7, 3'd6, 3'd5, 8'h01, 8'h02, 8'h03, 3'd1, 6'b111111};

    id_ex_pipe_reg_if #(.DW(8), .AW(3), .FW(3)) bus ();

    id_ex_pipe_reg #(.DW(8), .AW(3), .FW(3), .CW(4)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .flush     (flush),
        .p         (bus.slave),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [42:0] obs();
        return {bus.out_valid, bus.out_addr, bus.out_data, bus.out_alufn, bus.out_ctrl};
    endfunction

    function automatic logic [42:0] vld(input logic [41:0] x);
        return {1'b1, x};
    endfunction

    function automatic logic [42:0] bub(input logic [41:0] x);
        return {1'b0, x[41:6], x[5:0] & 6'b101001};
    endfunction

    task automatic edge_step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic v, input logic [41:0] x);
        bus.in_valid = v;
        bus.in_addr  = x[41:33];
        bus.in_data  = x[32:9];
        bus.in_alufn = x[8:6];
        bus.in_ctrl  = x[5:0];
    endtask

    task automatic do_reset();
        drive(1'b0, '0);
        bus.out_ready = 1'b0;
        flush = 1'b0;
        edge_step();
        rst_n = 1'b0;
        edge_step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs() !== 43'd0 || bus.in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset: out=%h in_ready=%b stall=%0d, want out=0 in_ready=1 stall=0",
                     obs(), bus.in_ready, stall_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, pay_a);
        edge_step();
        checks++;
        if (obs() !== vld(pay_a) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_a: out=%h rdy=%b, want %h rdy=1", obs(), bus.in_ready, vld(pay_a));
        end
        drive(1'b1, pay_b);
        edge_step();
        checks++;
        if (obs() !== vld(pay_b) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_b: out=%h rdy=%b, want %h rdy=1", obs(), bus.in_ready, vld(pay_b));
        end
        drive(1'b0, pay_b);
        edge_step();
        checks++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b stall=%0d, want valid=0 stall=0", bus.out_valid, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, pay_a);
        edge_step();
        drive(1'b1, pay_b);
        edge_step();
        drive(1'b0, pay_c);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs() !== vld(pay_a)) begin
                errors++;
                $display("FAIL bp_hold_%0d: out=%h want %h", i, obs(), vld(pay_a));
            end
            edge_step();
        end
        checks++;
        if (obs() !== vld(pay_a) || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL bp_stall: out=%h stall=%0d, want %h stall=3", obs(), stall_cnt, vld(pay_a));
        end
        bus.out_ready = 1'b1;
        edge_step();
        checks++;
        if (obs() !== vld(pay_b) || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_b: out=%h rdy=%b, want %h rdy=1", obs(), bus.in_ready, vld(pay_b));
        end
        edge_step();
        checks++;
        if (bus.out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL bp_empty: valid=%b stall=%0d, want valid=0 stall=3", bus.out_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, pay_a);
        edge_step();
        drive(1'b1, pay_b);
        edge_step();
        flush = 1'b1;
        drive(1'b1, pay_c);
        edge_step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || (bus.out_ctrl & 6'b010110) !== 6'd0
            || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL flush_full: valid=%b rdy=%b ctrl=%b stall=%0d, want 0 1 x0x00x 1",
                     bus.out_valid, bus.in_ready, bus.out_ctrl, stall_cnt);
        end
        // input offered while in_ready=1 is still dropped under flush
        drive(1'b1, pay_c);
        edge_step();
        flush = 1'b0;
        drive(1'b0, pay_c);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_c_%0d: valid=%b want 0", i, bus.out_valid);
            end
            edge_step();
        end
    endtask

    task automatic test_bubble();
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, pay_f);
        edge_step();
        checks++;
        if (obs() !== vld(pay_f) || bus.out_ctrl !== 6'b111111) begin
            errors++;
            $display("FAIL bubble_valid: out=%h want %h", obs(), vld(pay_f));
        end
        drive(1'b0, pay_a);
        edge_step();
        checks++;
        if (obs() !== bub(pay_f) || bus.out_ctrl !== 6'b101001) begin
            errors++;
            $display("FAIL bubble_mask: out=%h ctrl=%b, want %h ctrl=101001", obs(), bus.out_ctrl, bub(pay_f));
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        drive(1'b1, pay_a);
        edge_step();
        drive(1'b0, pay_b);
        for (int i = 1; i <= 20; i++) begin
            edge_step();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (stall_cnt !== exp_cnt || obs() !== vld(pay_a)) begin
                errors++;
                $display("FAIL sat_%0d: stall=%0d out=%h, want stall=%0d out=%h",
                         i, stall_cnt, obs(), exp_cnt, vld(pay_a));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, pay_a);
        edge_step();
        drive(1'b1, pay_b);
        edge_step();
        drive(1'b0, pay_c);
        edge_step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || stall_cnt !== 4'd0 || obs() !== 43'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rdy=%b stall=%0d out=%h, want 0 1 0 0",
                     bus.out_valid, bus.in_ready, stall_cnt, obs());
        end
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, pay_c);
        edge_step();
        drive(1'b0, pay_c);
        checks++;
        if (obs() !== vld(pay_c) || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_after: out=%h stall=%0d, want %h stall=0", obs(), stall_cnt, vld(pay_c));
        end
        edge_step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_drain: valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the multi-cycle pipelined datapath. It is the successor to the fixed 8-bit, 3-bit-address stage latch. It carries decoded register addresses, immediate, operands and control bits from decode to execute. It adds a valid/ready handshake with a one-entry skid buffer, so EX back-pressure stalls cleanly without combinational ready paths. It also adds a synchronous flush for branch/hazard squash, NOP-forcing of side-effecting control bits on bubbles, and a saturating stall counter for performance debug.

Parameters:
- DW, 8, operand/immediate width (m1, m2, imm)
- AW, 3, register-address width (ra, rb, rd)
- FW, 3, ALU function code width
- CW, 16, stall counter width

Ports:
- clk1  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held and incoming entries
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_addr  in  3*AW  {ra, rb, rd}
- in_data  in  3*DW  {imm, m1, m2}
- in_alufn  in  FW  ALU function
- in_ctrl  in  6  {regdst, regwrite, alusrc, memwrite, memread, memtoreg}
- out_valid  out  1  EX-side instruction valid
- out_ready  in  1  EX accepts this cycle
- out_addr  out  3*AW  registered {ra, rb, rd}
- out_data  out  3*DW  registered {imm, m1, m2}
- out_alufn  out  FW  registered ALU function
- out_ctrl  out  6  registered control; masked on bubble
- stall_cnt  out  CW  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n low, asynchronous): main and skid entries invalid, all payload registers 0, stall_cnt=0. Outputs are then out_valid=0, out_ctrl=0, out_addr/out_data/out_alufn=0 and in_ready=1.
- Storage consists of a main register (drives outputs) and a skid register, each with a valid flag. in_ready = !skid_valid and is registered-state only, with no combinational path from out_ready.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when the main register is empty or is transferring that cycle.
- Accept while the main register is occupied and not transferring: the payload goes to skid and skid_valid=1.
- Output transfer with skid_valid: skid moves into main and skid_valid=0. A simultaneous accept is impossible because in_ready=0.
- Output transfer with no skid and a simultaneous accept: main loads new input and out_valid stays 1, giving back-to-back throughput of 1 per cycle.
- Output transfer with no accept: out_valid goes to 0 next cycle.
- Stall hold: while out_valid && !out_ready, out_* must be stable cycle to cycle.
- Bubble masking: when out_valid=0, out_ctrl bits regwrite, memwrite and memread are forced to 0. The other out_ctrl bits and the payload hold their last value and are don't-care to EX.
- Flush (sampled at clock edge): next cycle main_valid=0 and skid_valid=0. Any same-cycle input is discarded, and a same-cycle output transfer still counts as completed. Flush has priority over all handshake events. Payload registers are not cleared.
- stall_cnt: +1 each cycle with out_valid && !out_ready and flush=0. It holds at 2^CW-1 and never wraps. It is cleared only by reset.
- Reset mid-stall: everything returns to reset values immediately and asynchronously. Both held entries are lost.

Decomposition:
- Shared package pipe_pkg: control-bit index constants (CTRL_REGDST=5 … CTRL_MEMTOREG=0), CTRL_W=6, and the bubble mask constant 6'b101001 (clears regwrite, memwrite and memread when ANDed).
- One natural sub-module: skid_buf, a generic width-parameterised valid/ready 2-entry register with flush. The stage module packs and unpacks fields around it and owns the masking and stall_cnt logic.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 every cycle with addr {1,2,3}, data {8'h05,8'h10,8'h20} then {4,5,6} → outputs appear 1 cycle later in order, out_valid held 1, in_ready held 1, stall_cnt=0.
- Back-pressure: send A and B back-to-back, with out_ready=0 for 3 cycles from A's arrival → out=A stable, B in skid, in_ready=0 after B, stall_cnt=3. Raising out_ready then delivers A then B with nothing lost or duplicated.
- Flush with full skid: main=A and skid=B, assert flush=1 with in_valid=1 (C) → next cycle out_valid=0, in_ready=1, out_ctrl regwrite/memwrite/memread=0, and C never appears.
- Bubble masking: accept one instruction with in_ctrl=6'b111111, then in_valid=0 → valid cycle shows 6'b111111, following cycle shows out_ctrl=6'b101001 with out_valid=0.
- Saturation at CW=4: hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15.
- Async reset: drop rst_n mid-stall, between clock edges → out_valid=0, in_ready=1 and stall_cnt=0 before the next edge. After release, the first accepted instruction passes normally.
